// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, BURST)
//   idx_width   : width of a requester index for n requesters
//   cnt_width   : width of a counter that must hold 0..m
//   rr_pick     : round-robin winner index; scans last+1, last+2, ... (mod n)
// Optional feature macro used by the arbiter: FIFO_WR_ARB_CHK_EN
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Upper bound on requesters that rr_pick can scan.
   localparam int MAX_REQ = 32;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int m);
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

   // Scans from the farthest position back toward last+1 so that the
   // closest requester after 'last' is the one left in the result.
   // Returns 'last' when nothing is requesting.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                  input int last,
                                  input int n);
      int idx;
      int win;
      win = last;
      for (int k = n; k >= 1; k--) begin
         idx = (last + k) % n;
         if (req[idx[4:0]]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_prio_picker.sv
// -----------------------------------------------------------------------------
// rr_prio_picker
// Combinational round-robin picker: the requester just after the last owner
// has highest priority, the last owner itself has lowest.
// Ports:
//   i_req        requests, one bit per requester
//   i_last       index of the previous grantee
//   o_winner_oh  one-hot winner (all zero when nothing requests)
//   o_valid      at least one request present
// -----------------------------------------------------------------------------
module rr_prio_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDXW    = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDXW-1:0]    i_last,
   output logic [NUM_REQ-1:0] o_winner_oh,
   output logic               o_valid
);

   logic [MAX_REQ-1:0] w_req_ext;
   int                 w_win;

   assign w_req_ext = MAX_REQ'(i_req);
   assign o_valid   = |i_req;

   always_comb begin
      w_win       = rr_pick(w_req_ext, int'(i_last), NUM_REQ);
      o_winner_oh = '0;
      if (o_valid) o_winner_oh[w_win[IDXW-1:0]] = 1'b1;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grantee may write up to MAX_BURST words per grant; one idle cycle always
// separates consecutive grants. FIFO full stalls the burst (grant held).
//
// Handshake: a word from requester i is transferred in a cycle when
// o_accept[i]=1, which happens only while i owns the grant, i_req[i]=1 and
// i_fifo_full=0; o_fifo_wr_en is exactly |o_accept, and o_fifo_data_in then
// carries that requester's slice of i_req_data.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_req, i_req_data   per-requester level request and packed data words
//   o_gnt               registered one-hot grant
//   o_accept            word from requester i taken this cycle
//   o_owner             index of current/last grantee
//   o_busy              FSM state debug view: 1 in BURST
//   o_fifo_wr_en        FIFO write enable
//   o_fifo_data_in      FIFO write data (0 outside BURST)
//   i_fifo_full         FIFO full
//   i_fifo_wr_ack       FIFO write ack, one cycle after an accepted write
//   i_fifo_overflow     FIFO overflow flag
//   o_err               sticky protocol error
//
// Macro FIFO_WR_ARB_CHK_EN: when defined, o_err flags missing/unexpected
// write acks and any overflow; when undefined o_err is 0 and the ack/overflow
// inputs are ignored.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int FIFO_WIDTH = 16,
   parameter  int MAX_BURST  = 4,
   localparam int IDXW       = idx_width(NUM_REQ),
   localparam int BCW        = cnt_width(MAX_BURST)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [NUM_REQ-1:0]            o_accept,
   output logic [IDXW-1:0]               o_owner,
   output logic                          o_busy,
   output logic                          o_fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]         o_fifo_data_in,
   input  logic                          i_fifo_full,
   input  logic                          i_fifo_wr_ack,
   input  logic                          i_fifo_overflow,
   output logic                          o_err
);

   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic [NUM_REQ-1:0]    r_gnt;
   logic [IDXW-1:0]       r_owner;
   logic [BCW-1:0]        r_beat;

   logic [NUM_REQ-1:0]    w_pick_oh;
   logic                  w_pick_vld;
   logic [IDXW-1:0]       w_pick_idx;
   logic                  w_take;
   logic                  w_last_beat;
   logic [FIFO_WIDTH-1:0] w_slice [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign w_slice[g] = i_req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
   end

   rr_prio_picker #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) u_picker (
      .i_req       (i_req),
      .i_last      (r_owner),
      .o_winner_oh (w_pick_oh),
      .o_valid     (w_pick_vld)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_oh[i]) w_pick_idx = IDXW'(i);
      end
   end

   // Reset suppresses the write so nothing reaches the FIFO in the reset cycle.
   assign w_take      = (r_state == BURST) & i_req[r_owner] & ~i_fifo_full & ~i_rst;
   assign w_last_beat = (r_beat == BCW'(MAX_BURST - 1));

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_vld) w_state_nxt = BURST;
         BURST:   if (!i_req[r_owner] || (w_take && w_last_beat)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant, owner and beat registers. Owner resets to the last index so the
   // first scan after reset starts at requester 0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gnt   <= '0;
         r_owner <= IDXW'(NUM_REQ - 1);
         r_beat  <= '0;
      end else begin
         if (r_state == IDLE && w_pick_vld) begin
            r_gnt   <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_beat  <= '0;
         end else begin
            if (w_state_nxt == IDLE) r_gnt <= '0;
            if (w_take) r_beat <= r_beat + 1'b1;
         end
      end
   end

   // Output logic
   always_comb begin
      o_accept       = '0;
      o_fifo_data_in = '0;
      o_busy         = (r_state == BURST);
      if (w_take) o_accept[r_owner] = 1'b1;
      if (r_state == BURST) o_fifo_data_in = w_slice[r_owner];
   end

   assign o_fifo_wr_en = w_take;
   assign o_gnt        = r_gnt;
   assign o_owner      = r_owner;

`ifdef FIFO_WR_ARB_CHK_EN
   logic r_ack_pend;
   logic r_err;

   // r_ack_pend is the ack the FIFO owes this cycle for last cycle's write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack_pend <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ack_pend <= w_take;
         if ((r_ack_pend != i_fifo_wr_ack) || i_fifo_overflow) r_err <= 1'b1;
      end
   end

   assign o_err = r_err;

`ifdef SIM
   a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_gnt));
   a_acc_in_gnt  : assert property (@(posedge i_clk) disable iff (i_rst) (o_accept & ~r_gnt) == '0);
   a_no_wr_full  : assert property (@(posedge i_clk) disable iff (i_rst) o_fifo_wr_en |-> !i_fifo_full);
`endif
`else
   logic w_unused_chk;
   assign w_unused_chk = i_fifo_wr_ack ^ i_fifo_overflow;
   assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, FIFO_WIDTH=16, MAX_BURST=4).
// A reference model of the arbitration rules runs on the falling edge and is
// compared with every DUT output each cycle; written words also go through an
// expected-data queue. Directed scenarios add hand-computed literal checks.
// Honours FIFO_WR_ARB_CHK_EN for the expected value of o_err.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int MB = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic           full, ack, ovf;
   logic [N-1:0]   o_gnt, o_accept;
   logic [1:0]     o_owner;
   logic           o_busy, o_fifo_wr_en, o_err;
   logic [W-1:0]   o_fifo_data_in;

   fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req           (req),
      .i_req_data      (req_data),
      .o_gnt           (o_gnt),
      .o_accept        (o_accept),
      .o_owner         (o_owner),
      .o_busy          (o_busy),
      .o_fifo_wr_en    (o_fifo_wr_en),
      .o_fifo_data_in  (o_fifo_data_in),
      .i_fifo_full     (full),
      .i_fifo_wr_ack   (ack),
      .i_fifo_overflow (ovf),
      .o_err           (o_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // observation state shared with the stimulus side
   logic         last_wr_en = 1'b0;
   logic         withhold   = 1'b0;
   int           wr_total   = 0;
   int           gnt_log[$];
   logic [N-1:0] prev_gnt   = '0;
   logic [W-1:0] exp_q[$];

   // reference model
   bit m_known    = 0;
   bit m_busy     = 0;
   int m_owner    = N - 1;
   int m_words    = 0;
   bit m_err      = 0;
   bit m_ack_pend = 0;

   always @(negedge clk) begin
      bit           take;
      bit           found;
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_acc;
      logic [W-1:0] e_data;

      last_wr_en = o_fifo_wr_en;
      if (o_fifo_wr_en === 1'b1) wr_total++;
      if (o_gnt != '0 && prev_gnt == '0) gnt_log.push_back(int'(o_owner));
      prev_gnt = o_gnt;

      take = m_busy && req[m_owner] && !full && !rst;
      if (m_known) begin
         e_gnt  = m_busy ? (N'(1) << m_owner) : '0;
         e_acc  = take ? (N'(1) << m_owner) : '0;
         e_data = m_busy ? req_data[m_owner*W +: W] : '0;
         chk("gnt",    o_gnt,          e_gnt);
         chk("accept", o_accept,       e_acc);
         chk("owner",  o_owner,        m_owner);
         chk("busy",   o_busy,         m_busy);
         chk("wr_en",  o_fifo_wr_en,   take);
         chk("data",   o_fifo_data_in, e_data);
         chk("err",    o_err,          m_err);
         if (take) exp_q.push_back(e_data);
         if (o_fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
            else chk("sb_data", o_fifo_data_in, exp_q.pop_front());
         end
      end

      if (rst) begin
         m_known = 1; m_busy = 0; m_owner = N - 1; m_words = 0;
         m_err = 0; m_ack_pend = 0;
      end else if (m_known) begin
`ifdef FIFO_WR_ARB_CHK_EN
         if ((m_ack_pend != ack) || ovf) m_err = 1;
`endif
         m_ack_pend = take;
         if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               if (!found && req[(m_owner + k) % N]) begin
                  m_owner = (m_owner + k) % N;
                  found   = 1;
               end
            end
            if (found) begin
               m_busy  = 1;
               m_words = 0;
            end
         end else if (!req[m_owner]) begin
            m_busy = 0;
         end else if (take) begin
            m_words++;
            if (m_words == MB) m_busy = 0;
         end
      end
   end

   // driver tasks
   int cyc = 0;

   task automatic drive_data();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'((i + 1) * 4096 + (cyc & 12'hfff));
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         ack = last_wr_en & ~withhold;
         drive_data();
      end
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic exp_chk_err;
   int   base;
   int   n0;

   initial begin
`ifdef FIFO_WR_ARB_CHK_EN
      exp_chk_err = 1'b1;
`else
      exp_chk_err = 1'b0;
`endif
      req = '0; full = 0; ack = 0; ovf = 0; rst = 1;
      drive_data();
      tick(2);
      rst = 0;
      tick(1);
      chk("rst_gnt",   o_gnt,   4'b0000);
      chk("rst_owner", o_owner, 2'd3);
      chk("rst_busy",  o_busy,  1'b0);
      chk("rst_err",   o_err,   1'b0);

      // single requester, full burst, one idle cycle, re-grant
      req  = 4'b0001;
      base = wr_total;
      tick(1);
      chk("t1_gnt_latency", o_gnt, 4'b0001);
      tick(4);
      chk("t1_gnt_drop", o_gnt, 4'b0000);
      chk("t1_words", wr_total - base, 4);
      tick(1);
      chk("t1_regrant", o_gnt, 4'b0001);
      req = '0;
      tick(3);

      // all requesting: order 0,1,2,3,0
      do_reset();
      n0  = gnt_log.size();
      req = 4'b1111;
      tick(26);
      req = '0;
      tick(2);
      chk("t2_grant_count_ge5", gnt_log.size() >= n0 + 5, 1);
      for (int k = 0; k < 5; k++) begin
         if (gnt_log.size() > n0 + k) chk("t2_grant_order", gnt_log[n0 + k], k % 4);
      end

      // FIFO full stall mid-burst
      do_reset();
      req  = 4'b0010;
      base = wr_total;
      tick(2);
      full = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_stall_wr_en", o_fifo_wr_en, 1'b0);
         chk("t3_stall_gnt",   o_gnt,        4'b0010);
         tick(1);
      end
      full = 0;
      tick(3);
      chk("t3_words", wr_total - base, 4);
      chk("t3_gnt_drop", o_gnt, 4'b0000);
      req = '0;
      tick(2);

      // requester 2 drops after 2 words, requester 3 gets the next grant
      do_reset();
      req  = 4'b0100;
      base = wr_total;
      tick(3);
      chk("t4_words", wr_total - base, 2);
      req = 4'b1000;
      tick(1);
      chk("t4_exit", o_gnt, 4'b0000);
      tick(1);
      chk("t4_next_gnt",   o_gnt,   4'b1000);
      chk("t4_next_owner", o_owner, 2'd3);
      req = '0;
      tick(3);

      // reset mid-burst at beat 2
      do_reset();
      req = 4'b0001;
      tick(3);
      rst = 1;
      #1;
      chk("t5_no_write_in_rst", o_fifo_wr_en, 1'b0);
      tick(1);
      rst = 0;
      chk("t5_gnt",   o_gnt,   4'b0000);
      chk("t5_owner", o_owner, 2'd3);
      chk("t5_err",   o_err,   1'b0);
      tick(1);
      chk("t5_regrant", o_gnt, 4'b0001);
      req = '0;
      tick(2);

      // withheld write ack, then overflow pulse
      do_reset();
      req = 4'b0001;
      tick(1);
      withhold = 1;
      tick(1);
      withhold = 0;
      tick(1);
      chk("t6_err_ack", o_err, exp_chk_err);
      tick(3);
      chk("t6_err_sticky", o_err, exp_chk_err);
      do_reset();
      chk("t6_err_clear", o_err, 1'b0);
      ovf = 1;
      tick(1);
      ovf = 0;
      tick(1);
      chk("t6_err_overflow", o_err, exp_chk_err);

      req = '0;
      tick(3);
      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
